// File: rtl/data_mem_be.sv
// Byte-addressable data memory with RV32 byte/half/word access, a one-entry
// store write buffer with store-to-load forwarding, and registered fault reporting.
module data_mem_be #(
    parameter int unsigned ADDRW = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        dout_valid,
    output logic        fault,
    output logic [31:0] fault_addr
);

    localparam int unsigned DEPTH = 2 ** ADDRW;

    logic [31:0]      mem_q [DEPTH];

    logic             wb_valid_q, wb_valid_d;
    logic [3:0]       wb_mask_q, wb_mask_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic [ADDRW-1:0] wb_idx_q, wb_idx_d;

    logic [31:0]      dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             fault_q, fault_d;
    logic [31:0]      fault_addr_q, fault_addr_d;

    logic [1:0]       off;
    logic [ADDRW-1:0] widx;
    logic             width_ok, align_ok, range_ok, legal;
    logic             acc_store, acc_load;
    logic [3:0]       st_mask;
    logic [31:0]      st_data;
    logic [31:0]      merged;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      load_res;

    always_comb begin
        off      = addr[1:0];
        widx     = addr[ADDRW+1:2];
        range_ok = (addr[31:ADDRW+2] == '0);

        width_ok = 1'b0;
        align_ok = 1'b0;
        case (funct3)
            3'b000:  begin width_ok = 1'b1; align_ok = 1'b1; end
            3'b001:  begin width_ok = 1'b1; align_ok = (off[0] == 1'b0); end
            3'b010:  begin width_ok = 1'b1; align_ok = (off == 2'b00); end
            3'b100:  begin width_ok = !we;  align_ok = 1'b1; end
            3'b101:  begin width_ok = !we;  align_ok = (off[0] == 1'b0); end
            default: begin width_ok = 1'b0; align_ok = 1'b0; end
        endcase
        legal     = width_ok && align_ok && range_ok;
        acc_store = req_valid && we && legal;
        acc_load  = req_valid && !we && legal;

        case (funct3[1:0])
            2'b00:   begin st_mask = 4'b0001 << off; st_data = {4{din[7:0]}};  end
            2'b01:   begin st_mask = 4'b0011 << off; st_data = {2{din[15:0]}}; end
            default: begin st_mask = 4'b1111;        st_data = din;            end
        endcase

        // Buffered lanes override the array: the buffer commits on this same edge.
        merged = mem_q[widx];
        for (int unsigned i = 0; i < 4; i++) begin
            if (wb_valid_q && (wb_idx_q == widx) && wb_mask_q[i]) begin
                merged[8*i +: 8] = wb_data_q[8*i +: 8];
            end
        end

        case (off)
            2'b00:   byte_sel = merged[7:0];
            2'b01:   byte_sel = merged[15:8];
            2'b10:   byte_sel = merged[23:16];
            default: byte_sel = merged[31:24];
        endcase
        half_sel = off[1] ? merged[31:16] : merged[15:0];

        case (funct3)
            3'b000:  load_res = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_res = {24'h0, byte_sel};
            3'b001:  load_res = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_res = {16'h0, half_sel};
            default: load_res = merged;
        endcase
    end

    always_comb begin
        wb_valid_d   = acc_store;
        wb_mask_d    = wb_mask_q;
        wb_data_d    = wb_data_q;
        wb_idx_d     = wb_idx_q;
        dout_valid_d = acc_load;
        dout_d       = dout_q;
        fault_d      = req_valid && !legal;
        fault_addr_d = fault_addr_q;
        if (acc_store) begin
            wb_mask_d = st_mask;
            wb_data_d = st_data;
            wb_idx_d  = widx;
        end
        if (acc_load) begin
            dout_d = load_res;
        end
        if (req_valid && !legal) begin
            fault_addr_d = addr;
        end
    end

    // Array has no reset; a reset edge only suppresses the pending buffer commit.
    always_ff @(posedge clk) begin
        if (wb_valid_q && !rst) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wb_mask_q[i]) begin
                    mem_q[wb_idx_q][8*i +: 8] <= wb_data_q[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_q   <= 1'b0;
            wb_mask_q    <= '0;
            wb_data_q    <= '0;
            wb_idx_q     <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            wb_valid_q   <= wb_valid_d;
            wb_mask_q    <= wb_mask_d;
            wb_data_q    <= wb_data_d;
            wb_idx_q     <= wb_idx_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign fault      = fault_q;
    assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_data_mem_be.sv
// Self-checking bench for data_mem_be: directed scenarios plus random traffic
// compared against a byte-array reference model.
module tb_data_mem_be;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] din = '0;
    logic [31:0] dout;
    logic        dout_valid;
    logic        fault;
    logic [31:0] fault_addr;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    logic [7:0]  mb [4096];
    logic [31:0] exp_dout = '0;
    logic [31:0] exp_fa   = '0;

    data_mem_be #(.ADDRW(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .we         (we),
        .funct3     (funct3),
        .addr       (addr),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .fault      (fault),
        .fault_addr (fault_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic bit is_legal(input logic w, input logic [2:0] f3, input logic [31:0] a);
        int unsigned sz;
        if (a >= 32'h1000) return 1'b0;
        if (w && !(f3 inside {3'b000, 3'b001, 3'b010})) return 1'b0;
        if (!w && !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 1'b0;
        sz = 1 << f3[1:0];
        return (a % sz) == 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        int unsigned i;
        i = a[11:0];
        case (f3)
            3'b000:  return {{24{mb[i][7]}}, mb[i]};
            3'b100:  return {24'h0, mb[i]};
            3'b001:  return {{16{mb[i+1][7]}}, mb[i+1], mb[i]};
            3'b101:  return {16'h0, mb[i+1], mb[i]};
            default: return {mb[i+3], mb[i+2], mb[i+1], mb[i]};
        endcase
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int unsigned i;
        int unsigned n;
        logic [31:0] dd;
        i  = a[11:0];
        n  = 1 << f3[1:0];
        dd = d;
        for (int unsigned k = 0; k < n; k++) begin
            mb[i+k] = dd[7:0];
            dd = dd >> 8;
        end
    endtask

    task automatic check_outputs(input logic exp_dv, input logic exp_f);
        check("dout_valid", {31'h0, dout_valid}, {31'h0, exp_dv});
        check("fault", {31'h0, fault}, {31'h0, exp_f});
        check("dout", dout, exp_dout);
        check("fault_addr", fault_addr, exp_fa);
        check("fault_and_valid", {31'h0, fault & dout_valid}, 32'h0);
    endtask

    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        bit ok;
        ok        = is_legal(w, f3, a);
        req_valid = 1'b1;
        we        = w;
        funct3    = f3;
        addr      = a;
        din       = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (!ok) begin
            exp_fa = a;
            check_outputs(1'b0, 1'b1);
        end else if (w) begin
            model_store(f3, a, d);
            check_outputs(1'b0, 1'b0);
        end else begin
            exp_dout = model_load(f3, a);
            check_outputs(1'b1, 1'b0);
        end
    endtask

    task automatic idle();
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check_outputs(1'b0, 1'b0);
    endtask

    task automatic reset_check();
        exp_dout = '0;
        exp_fa   = '0;
        check_outputs(1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] ra, rd;
        logic [2:0]  rf;
        logic        rw;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        reset_check();

        for (int unsigned w = 0; w < 64; w++) begin
            issue(1'b1, 3'b010, w * 4, $urandom);
        end

        issue(1'b1, 3'b010, 32'h40, 32'hDEADBEEF);
        idle();
        issue(1'b0, 3'b010, 32'h40, 32'h0);
        check("plan_lw40", dout, 32'hDEADBEEF);

        issue(1'b1, 3'b000, 32'h80, 32'h11);
        issue(1'b1, 3'b000, 32'h81, 32'h22);
        issue(1'b1, 3'b000, 32'h82, 32'h33);
        issue(1'b1, 3'b000, 32'h83, 32'h44);
        issue(1'b0, 3'b010, 32'h80, 32'h0);
        check("plan_lw80", dout, 32'h44332211);
        issue(1'b0, 3'b000, 32'h83, 32'h0);
        check("plan_lb83", dout, 32'h00000044);
        issue(1'b0, 3'b001, 32'h82, 32'h0);
        check("plan_lh82", dout, 32'h00004433);

        issue(1'b1, 3'b010, 32'h10, 32'h000080FF);
        issue(1'b0, 3'b000, 32'h10, 32'h0);
        check("plan_lb10", dout, 32'hFFFFFFFF);
        issue(1'b0, 3'b100, 32'h10, 32'h0);
        check("plan_lbu10", dout, 32'h000000FF);
        issue(1'b0, 3'b001, 32'h10, 32'h0);
        check("plan_lh10", dout, 32'hFFFF80FF);
        issue(1'b0, 3'b101, 32'h10, 32'h0);
        check("plan_lhu10", dout, 32'h000080FF);

        issue(1'b1, 3'b010, 32'h20, 32'hAAAAAAAA);
        idle();
        issue(1'b1, 3'b001, 32'h22, 32'h00005555);
        issue(1'b0, 3'b010, 32'h20, 32'h0);
        check("plan_fwd", dout, 32'h5555AAAA);

        issue(1'b0, 3'b010, 32'h41, 32'h0);
        check("plan_fa41", fault_addr, 32'h00000041);
        issue(1'b1, 3'b001, 32'h43, 32'hFFFFFFFF);
        issue(1'b0, 3'b010, 32'h40, 32'h0);
        check("plan_nowrite", dout, 32'hDEADBEEF);
        issue(1'b0, 3'b010, 32'h1000, 32'h0);
        issue(1'b1, 3'b100, 32'h44, 32'h12345678);
        issue(1'b1, 3'b101, 32'h44, 32'h12345678);
        issue(1'b0, 3'b011, 32'h44, 32'h0);

        issue(1'b1, 3'b010, 32'h30, 32'h01020304);
        issue(1'b1, 3'b000, 32'h31, 32'h000000A5);
        issue(1'b1, 3'b001, 32'h32, 32'h0000C3D4);
        issue(1'b0, 3'b010, 32'h30, 32'h0);
        check("b2b_stores", dout, 32'hC3D4A504);
        issue(1'b1, 3'b010, 32'h34, 32'hCAFEF00D);
        issue(1'b0, 3'b010, 32'h38, 32'h0);

        issue(1'b0, 3'b010, 32'h41, 32'h0);
        req_valid = 1'b1;
        we        = 1'b1;
        funct3    = 3'b010;
        addr      = 32'h60;
        din       = 32'h12345678;
        @(posedge clk);
        #1;
        check_outputs(1'b0, 1'b0);
        rst = 1'b1;
        din = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        reset_check();
        issue(1'b0, 3'b010, 32'h60, 32'h0);

        for (int unsigned n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                idle();
            end else begin
                rw = 1'($urandom_range(0, 1));
                rf = 3'($urandom_range(0, 7));
                ra = 32'($urandom_range(0, 63));
                if ($urandom_range(0, 19) == 0) begin
                    ra = ra | (32'h1 << $urandom_range(12, 31));
                end
                rd = $urandom;
                issue(rw, rf, ra, rd);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/data_mem_be.md
# data_mem_be

Parametrised byte-addressable data memory for the core's MEM stage. Supports RV32 byte/half/word stores through per-lane byte enables and sign- or zero-extended loads, with a fixed one-cycle load latency. Stores land through a one-entry write buffer, and a load issued in the following cycle sees that store through store-to-load forwarding. Misaligned, out-of-range and illegal-width accesses are rejected and reported on a registered fault pulse.

## Interface
- ADDRW, 10, word-address width; depth = 2**ADDRW 32-bit words (4·2**ADDRW bytes)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- req_valid  in  1  request present this cycle; no backpressure, every valid request is accepted
- we  in  1  1 = store, 0 = load; ignored when req_valid=0
- funct3  in  3  RV32 width code: 000 b, 001 h, 010 w, 100 bu, 101 hu (bu/hu are loads only)
- addr  in  32  byte address
- din  in  32  store data; lane-aligned from bit 0 (sb uses din[7:0], sh uses din[15:0])
- dout  out  32  extended load result
- dout_valid  out  1  dout holds the result of the load accepted on the previous edge
- fault  out  1  one-cycle pulse: request accepted on the previous edge was rejected
- fault_addr  out  32  addr of the rejected request; holds its value until the next fault

## Operation
- Word index = addr[ADDRW+1:2]; byte offset = addr[1:0].
- Legality checks, all of which must pass:
  - Width: store funct3 ∈ {000,001,010}; load funct3 ∈ {000,001,010,100,101}.
  - Alignment: h/hu need addr[0]=0; w needs addr[1:0]=00.
  - Range: addr[31:ADDRW+2] must be all zero.
- Illegal request: no array write, no write-buffer load, dout_valid=0 next cycle, fault=1 next cycle, fault_addr captures addr.
- Legal store:
  - Byte mask: b → 1<<off; h → 0011<<off; w → 1111.
  - Data is replicated into the selected lanes: b → {4{din[7:0]}}; h → {2{din[15:0]}}.
  - On the accepting edge, mask, data and word index are loaded into the write buffer (wb_valid=1).
  - On the next edge the buffer writes the masked lanes into the array. A new store accepted on that same edge reloads the buffer. Otherwise wb_valid clears.
- Legal load:
  - The word is read on the accepting edge into a registered read stage.
  - Forwarding: if wb_valid=1 and the buffer's word index equals the load's index on that edge, each masked lane is taken from the buffer data instead of the array.
  - Lane select by the registered offset. b/h sign-extend from bit 7/15; bu/hu zero-extend; w passes through.
- Array contents are not initialised or cleared by rst.
- Only one request per cycle; a load and a store are never simultaneous.

## Timing
- Reset values: dout=0, dout_valid=0, fault=0, fault_addr=0, wb_valid=0.
- Load latency: request valid in cycle N → dout/dout_valid=1 in cycle N+1.
- dout keeps its last value while dout_valid=0.
- Store visibility:
  - A store accepted at edge E is committed to the array at edge E+1.
  - A load accepted at E+1 (same word) must return the new bytes via forwarding.
  - Loads accepted at E+2 or later read them from the array.
- Back-to-back stores to the same word, one per cycle: each commits in order, and the later store's lanes win.
- Store followed by a load to a different word: no forwarding, array value returned.
- rst=1 at an edge:
  - A pending buffer entry is discarded (no array write).
  - The request presented on that edge is ignored.
  - All outputs take their reset values the next cycle.
- fault and dout_valid are never both 1.
- Stores never assert dout_valid.

## Test plan
- sw 0xDEADBEEF to addr 0x40, idle, lw 0x40 → dout=0xDEADBEEF, dout_valid=1 exactly one cycle after the lw.
- sb 0x11,0x22,0x33,0x44 to 0x80..0x83 (consecutive cycles), then lw 0x80 → 0x44332211. Then lb 0x83 → 0x00000044; lh 0x82 → 0x00004433.
- sw 0x000080FF to 0x10, then lb 0x10 → 0xFFFFFFFF; lbu 0x10 → 0x000000FF; lh 0x10 → 0xFFFF80FF; lhu 0x10 → 0x000080FF.
- Forwarding, with word 0x20 = 0xAAAAAAAA: sh 0x5555 to 0x22 in cycle N, then lw 0x20 in cycle N+1 → 0x5555AAAA in N+2.
- Illegal requests:
  - lw 0x41 → fault=1, fault_addr=0x41, dout_valid=0.
  - sh to 0x43 → no write; a later lw 0x40 returns the old value.
  - With ADDRW=10, lw 0x1000 → fault.
  - Store with funct3=100 → fault.
- Reset mid-operation:
  - sw 0x12345678 to 0x60 accepted at edge E, rst=1 at E+1, then lw 0x60 → the old value, not 0x12345678.
  - All outputs are 0 the cycle after reset.
